// File: rtl/axis_pkg.sv
// Shared AXI-Stream types: sample format, TLAST checker state and the
// tlast/sop sideband carried alongside the data in pipeline registers.
package axis_pkg;

    localparam int SAMPLE_W = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic {
        SYNC = 1'b0,
        HUNT = 1'b1
    } tlast_chk_state_t;

    typedef struct packed {
        logic tlast;
        logic sop;
    } axis_user_t;

endpackage

// File: rtl/axis_pipe_reg.sv
// One-stage AXI-Stream register with full throughput: a new beat can load
// in the same cycle the held beat drains, so there are no bubbles.
module axis_pipe_reg
    import axis_pkg::*;
#(
    parameter int BUS_NUM = 2,
    parameter int USER_W  = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_tvalid,
    output logic                       in_tready,
    input  sample_t [BUS_NUM-1:0]      in_tdata,
    input  logic    [USER_W-1:0]       in_tuser,
    output logic                       out_tvalid,
    input  logic                       out_tready,
    output sample_t [BUS_NUM-1:0]      out_tdata,
    output logic    [USER_W-1:0]       out_tuser
);

    logic                  valid_q, valid_d;
    sample_t [BUS_NUM-1:0] data_q, data_d;
    logic    [USER_W-1:0]  user_q, user_d;

    assign in_tready  = ~valid_q | out_tready;
    assign out_tvalid = valid_q;
    assign out_tdata  = data_q;
    assign out_tuser  = user_q;

    // Load a new beat when accepted, otherwise empty the stage once the sink takes it.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        user_d  = user_q;
        if (in_tvalid && in_tready) begin
            valid_d = 1'b1;
            data_d  = in_tdata;
            user_d  = in_tuser;
        end else if (out_tready) begin
            valid_d = 1'b0;
        end
    end

    // Storage for the held beat; reset discards anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            user_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            user_q  <= user_d;
        end
    end

endmodule

// File: rtl/axis_tlast_check.sv
// Receive-side packet framing checker. Verifies every packet is exactly
// PACK_SIZE/BUS_NUM beats with TLAST on the final beat, forwards beats
// through one register stage tagged with sop/tlast, and after a missing
// TLAST drops beats until the next TLAST to regain packet alignment.
module axis_tlast_check
    import axis_pkg::*;
#(
    parameter int PACK_SIZE = 8192,
    parameter int BUS_NUM   = 2,
    parameter int CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  in_tvalid,
    output logic                  in_tready,
    input  logic                  in_tlast,
    input  sample_t [BUS_NUM-1:0] in_tdata,
    output logic                  out_tvalid,
    input  logic                  out_tready,
    output logic                  out_tlast,
    output logic                  out_sop,
    output sample_t [BUS_NUM-1:0] out_tdata,
    output logic                  err_early,
    output logic                  err_late,
    output logic                  err_sticky,
    input  logic                  err_clr,
    output logic [CNT_W-1:0]      pkt_cnt,
    output logic [CNT_W-1:0]      err_cnt
);

    localparam int                    N         = PACK_SIZE / BUS_NUM;
    localparam int                    CNTR_SIZE = $clog2(N);
    localparam logic [CNTR_SIZE-1:0]  LAST_IDX  = CNTR_SIZE'(N - 1);
    localparam logic [CNT_W-1:0]      CNT_MAX   = '1;

    tlast_chk_state_t       state_q, state_d;
    logic [CNTR_SIZE-1:0]   beat_idx_q, beat_idx_d;
    logic                   err_early_q, err_early_d;
    logic                   err_late_q, err_late_d;
    logic                   err_sticky_q, err_sticky_d;
    logic [CNT_W-1:0]       err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]       pkt_cnt_q, pkt_cnt_d;

    logic       hunting;
    logic       accept;
    logic       pipe_in_tvalid;
    logic       pipe_in_tready;
    axis_user_t pipe_in_user;
    axis_user_t pipe_out_user;

    // While hunting the input is always ready and beats never reach the register.
    assign hunting        = en & (state_q == HUNT);
    assign in_tready      = hunting | pipe_in_tready;
    assign accept         = in_tvalid & in_tready;
    assign pipe_in_tvalid = in_tvalid & ~hunting;

    assign pipe_in_user.tlast = in_tlast;
    assign pipe_in_user.sop   = en & (beat_idx_q == '0);

    axis_pipe_reg #(
        .BUS_NUM (BUS_NUM),
        .USER_W  ($bits(axis_user_t))
    ) u_pipe (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_tvalid  (pipe_in_tvalid),
        .in_tready  (pipe_in_tready),
        .in_tdata   (in_tdata),
        .in_tuser   (pipe_in_user),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready),
        .out_tdata  (out_tdata),
        .out_tuser  (pipe_out_user)
    );

    assign out_tlast  = pipe_out_user.tlast;
    assign out_sop    = pipe_out_user.sop;
    assign err_early  = err_early_q;
    assign err_late   = err_late_q;
    assign err_sticky = err_sticky_q;
    assign err_cnt    = err_cnt_q;
    assign pkt_cnt    = pkt_cnt_q;

    // Framing FSM and beat index: classify each accepted beat against its position.
    always_comb begin
        state_d     = state_q;
        beat_idx_d  = beat_idx_q;
        err_early_d = 1'b0;
        err_late_d  = 1'b0;
        pkt_cnt_d   = pkt_cnt_q;
        if (!en) begin
            state_d    = SYNC;
            beat_idx_d = '0;
        end else if (accept) begin
            if (state_q == HUNT) begin
                if (in_tlast) begin
                    state_d    = SYNC;
                    beat_idx_d = '0;
                end
            end else if (in_tlast) begin
                beat_idx_d = '0;
                if (beat_idx_q == LAST_IDX) begin
                    pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
                end else begin
                    err_early_d = 1'b1;
                end
            end else if (beat_idx_q == LAST_IDX) begin
                err_late_d = 1'b1;
                state_d    = HUNT;
                beat_idx_d = '0;
            end else begin
                beat_idx_d = beat_idx_q + CNTR_SIZE'(1);
            end
        end
    end

    // Error statistics: a new error takes priority over a simultaneous clear.
    always_comb begin
        err_sticky_d = err_sticky_q;
        err_cnt_d    = err_cnt_q;
        if (err_early_d || err_late_d) begin
            err_sticky_d = 1'b1;
            if (err_clr) begin
                err_cnt_d = CNT_W'(1);
            end else if (err_cnt_q != CNT_MAX) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
        end else if (err_clr) begin
            err_sticky_d = 1'b0;
            err_cnt_d    = '0;
        end
    end

    // Checker state, pulses and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SYNC;
            beat_idx_q   <= '0;
            err_early_q  <= 1'b0;
            err_late_q   <= 1'b0;
            err_sticky_q <= 1'b0;
            err_cnt_q    <= '0;
            pkt_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            beat_idx_q   <= beat_idx_d;
            err_early_q  <= err_early_d;
            err_late_q   <= err_late_d;
            err_sticky_q <= err_sticky_d;
            err_cnt_q    <= err_cnt_d;
            pkt_cnt_q    <= pkt_cnt_d;
        end
    end

endmodule

// File: tb/tb_axis_tlast_check.sv
// Testbench for axis_tlast_check with 8-beat packets (PACK_SIZE=16, BUS_NUM=2)
// and 4-bit counters so that error-count saturation is reachable quickly.
module tb_axis_tlast_check;
    import axis_pkg::*;

    localparam int PACK_SIZE = 16;
    localparam int BUS_NUM   = 2;
    localparam int CNT_W     = 4;
    localparam int N         = PACK_SIZE / BUS_NUM;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  en = 1'b0;
    logic                  in_tvalid = 1'b0;
    logic                  in_tready;
    logic                  in_tlast = 1'b0;
    sample_t [BUS_NUM-1:0] in_tdata = '0;
    logic                  out_tvalid;
    logic                  out_tready = 1'b0;
    logic                  out_tlast;
    logic                  out_sop;
    sample_t [BUS_NUM-1:0] out_tdata;
    logic                  err_early;
    logic                  err_late;
    logic                  err_sticky;
    logic                  err_clr = 1'b0;
    logic [CNT_W-1:0]      pkt_cnt;
    logic [CNT_W-1:0]      err_cnt;

    axis_tlast_check #(
        .PACK_SIZE (PACK_SIZE),
        .BUS_NUM   (BUS_NUM),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .in_tvalid  (in_tvalid),
        .in_tready  (in_tready),
        .in_tlast   (in_tlast),
        .in_tdata   (in_tdata),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready),
        .out_tlast  (out_tlast),
        .out_sop    (out_sop),
        .out_tdata  (out_tdata),
        .err_early  (err_early),
        .err_late   (err_late),
        .err_sticky (err_sticky),
        .err_clr    (err_clr),
        .pkt_cnt    (pkt_cnt),
        .err_cnt    (err_cnt)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Hard time limit so a broken design can never hang the run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: time limit reached before end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: the packet position is a plain beat count, the output
    // register is a queue of pending beats, and the statistics are integers.
    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        sop;
    } beat_t;

    beat_t m_q[$];
    int    m_pos;
    bit    m_hunt;
    int    m_pkt;
    int    m_err;
    bit    m_sticky;
    bit    m_early;
    bit    m_late;
    bit    last_accept;

    task automatic modelReset();
        m_q.delete();
        m_pos    = 0;
        m_hunt   = 1'b0;
        m_pkt    = 0;
        m_err    = 0;
        m_sticky = 1'b0;
        m_early  = 1'b0;
        m_late   = 1'b0;
    endtask

    // Drive one cycle of inputs with fresh random data.
    task automatic applyStimulus(input bit e, input bit v, input bit l, input bit r, input bit c);
        en         = e;
        in_tvalid  = v;
        in_tlast   = l;
        out_tready = r;
        err_clr    = c;
        in_tdata   = $urandom;
    endtask

    // Check handshake and output beat mid-cycle, advance the model across the
    // clock edge, then check pulses and counters just after the edge.
    task automatic checkOutput();
        bit    exp_ready;
        bit    acc;
        bit    e_ev;
        bit    l_ev;
        bit    good;
        beat_t b;
        @(negedge clk);
        if (!en) begin
            m_hunt = 1'b0;
            m_pos  = 0;
        end
        exp_ready = m_hunt || (m_q.size() == 0) || out_tready;
        chk("in_tready", in_tready, exp_ready);
        chk("out_tvalid", out_tvalid, m_q.size() != 0);
        if (m_q.size() != 0) begin
            chk("out_tdata", out_tdata, m_q[0].data);
            chk("out_tlast", out_tlast, m_q[0].last);
            chk("out_sop", out_sop, m_q[0].sop);
        end
        acc  = in_tvalid && exp_ready;
        e_ev = 1'b0;
        l_ev = 1'b0;
        good = 1'b0;
        if (m_q.size() != 0 && out_tready) b = m_q.pop_front();
        if (acc) begin
            b.data = in_tdata;
            b.last = in_tlast;
            if (!en) begin
                b.sop = 1'b0;
                m_q.push_back(b);
            end else if (m_hunt) begin
                if (in_tlast) m_hunt = 1'b0;
            end else begin
                b.sop = (m_pos == 0);
                m_q.push_back(b);
                if (in_tlast) begin
                    if (m_pos == N - 1) good = 1'b1;
                    else e_ev = 1'b1;
                    m_pos = 0;
                end else if (m_pos == N - 1) begin
                    l_ev   = 1'b1;
                    m_hunt = 1'b1;
                    m_pos  = 0;
                end else begin
                    m_pos++;
                end
            end
        end
        if (e_ev || l_ev) begin
            m_sticky = 1'b1;
            m_err    = err_clr ? 1 : ((m_err < CNT_MAX) ? m_err + 1 : CNT_MAX);
        end else if (err_clr) begin
            m_sticky = 1'b0;
            m_err    = 0;
        end
        if (good) m_pkt = (m_pkt + 1) % (CNT_MAX + 1);
        m_early     = e_ev;
        m_late      = l_ev;
        last_accept = acc;
        @(posedge clk);
        #1;
        chk("err_early", err_early, m_early);
        chk("err_late", err_late, m_late);
        chk("err_sticky", err_sticky, m_sticky);
        chk("err_cnt", err_cnt, m_err);
        chk("pkt_cnt", pkt_cnt, m_pkt);
    endtask

    // Asynchronous reset in the middle of a cycle; everything must clear at once.
    task automatic doReset();
        applyStimulus(1, 0, 0, 1, 0);
        rst_n = 1'b0;
        #2;
        chk("rst_out_tvalid", out_tvalid, 0);
        chk("rst_in_tready", in_tready, 1);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_err_sticky", err_sticky, 0);
        chk("rst_err_early", err_early, 0);
        chk("rst_err_late", err_late, 0);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Directed vectors with hand-derived expectations for pulses and counters.
    typedef struct {
        bit en;
        bit vld;
        bit last;
        bit ordy;
        bit clr;
        bit x_early;
        bit x_late;
        bit x_sticky;
        int x_pkt;
        int x_err;
    } vec_t;

    vec_t tbl[$];

    task automatic addVec(input int count, input bit last, input bit clr, input bit vld,
                          input bit xe, input bit xl, input bit xs, input int xp, input int xr);
        vec_t v;
        for (int i = 0; i < count; i++) begin
            v.en = 1'b1; v.vld = vld; v.last = last; v.ordy = 1'b1; v.clr = clr;
            v.x_early = xe; v.x_late = xl; v.x_sticky = xs; v.x_pkt = xp; v.x_err = xr;
            tbl.push_back(v);
        end
    endtask

    bit rnd_e;
    bit rnd_v;
    bit rnd_l;
    int gen;

    // Main test sequence.
    initial begin
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_tvalid", out_tvalid, 0);
        chk("reset_in_tready", in_tready, 1);
        chk("reset_out_sop", out_sop, 0);
        chk("reset_out_tlast", out_tlast, 0);
        chk("reset_err_early", err_early, 0);
        chk("reset_err_late", err_late, 0);
        chk("reset_err_sticky", err_sticky, 0);
        chk("reset_pkt_cnt", pkt_cnt, 0);
        chk("reset_err_cnt", err_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Three clean packets at full rate.
        $display("[TB] three clean packets");
        for (int p = 0; p < 3; p++)
            for (int b = 0; b < N; b++) begin
                applyStimulus(1, 1, b == N - 1, 1, 0);
                checkOutput();
            end
        applyStimulus(1, 0, 0, 1, 0);
        checkOutput();
        chk("pkt_after_3", pkt_cnt, 3);

        // Early TLAST, late TLAST with resync, then clear racing an error.
        $display("[TB] directed framing table");
        doReset();
        addVec(4, 0, 0, 1, 0, 0, 0, 0, 0);
        addVec(1, 1, 0, 1, 1, 0, 1, 0, 1);
        addVec(7, 0, 0, 1, 0, 0, 1, 0, 1);
        addVec(1, 1, 0, 1, 0, 0, 1, 1, 1);
        addVec(7, 0, 0, 1, 0, 0, 1, 1, 1);
        addVec(1, 0, 0, 1, 0, 1, 1, 1, 2);
        addVec(3, 0, 0, 1, 0, 0, 1, 1, 2);
        addVec(1, 1, 0, 1, 0, 0, 1, 1, 2);
        addVec(7, 0, 0, 1, 0, 0, 1, 1, 2);
        addVec(1, 1, 0, 1, 0, 0, 1, 2, 2);
        addVec(1, 1, 1, 1, 1, 0, 1, 2, 1);
        addVec(1, 0, 1, 0, 0, 0, 0, 2, 0);
        foreach (tbl[i]) begin
            applyStimulus(tbl[i].en, tbl[i].vld, tbl[i].last, tbl[i].ordy, tbl[i].clr);
            checkOutput();
            chk("tbl_err_early", err_early, tbl[i].x_early);
            chk("tbl_err_late", err_late, tbl[i].x_late);
            chk("tbl_err_sticky", err_sticky, tbl[i].x_sticky);
            chk("tbl_pkt_cnt", pkt_cnt, tbl[i].x_pkt);
            chk("tbl_err_cnt", err_cnt, tbl[i].x_err);
        end

        // Ten clean packets with random gaps and random back-pressure.
        $display("[TB] random back-pressure");
        doReset();
        for (int p = 0; p < 10; p++)
            for (int b = 0; b < N; b++) begin
                last_accept = 1'b0;
                for (int t = 0; t < 64 && !last_accept; t++) begin
                    applyStimulus(1, ($urandom % 4) != 0, b == N - 1, $urandom % 2, 0);
                    checkOutput();
                end
                if (!last_accept) chk("accept_timeout", 0, 1);
            end
        for (int t = 0; t < 3; t++) begin
            applyStimulus(1, 0, 0, 1, 0);
            checkOutput();
        end
        chk("pkt_after_10", pkt_cnt, 10);
        chk("drained", out_tvalid, 0);

        // Error counter saturation with back-to-back one-beat packets.
        $display("[TB] error counter saturation");
        for (int i = 0; i < CNT_MAX + 2; i++) begin
            applyStimulus(1, 1, 1, 1, 0);
            checkOutput();
        end
        chk("err_saturated", err_cnt, CNT_MAX);
        applyStimulus(1, 0, 0, 1, 1);
        checkOutput();
        chk("err_cleared", err_cnt, 0);

        // Disable mid-packet: pass-through with a stray TLAST, then a clean packet.
        $display("[TB] enable low pass-through");
        for (int b = 0; b < 3; b++) begin
            applyStimulus(1, 1, 0, 1, 0);
            checkOutput();
        end
        for (int b = 0; b < 5; b++) begin
            applyStimulus(0, 1, b == 2, 1, 0);
            checkOutput();
        end
        for (int b = 0; b < N; b++) begin
            applyStimulus(1, 1, b == N - 1, 1, 0);
            checkOutput();
        end
        chk("pkt_after_en", pkt_cnt, 11);
        chk("err_after_en", err_cnt, 0);

        // Reset while a beat is held under back-pressure.
        $display("[TB] reset mid-packet");
        applyStimulus(1, 1, 0, 1, 0); checkOutput();
        applyStimulus(1, 1, 0, 1, 0); checkOutput();
        applyStimulus(1, 1, 1, 1, 0); checkOutput();
        applyStimulus(1, 1, 0, 1, 0); checkOutput();
        applyStimulus(1, 1, 0, 0, 0); checkOutput();
        chk("held_before_reset", out_tvalid, 1);
        doReset();
        for (int b = 0; b < N; b++) begin
            applyStimulus(1, 1, b == N - 1, 1, 0);
            checkOutput();
        end
        chk("pkt_after_reset", pkt_cnt, 1);

        // Mixed random traffic: framing errors, enable drops, clears, stalls.
        $display("[TB] random mixed traffic");
        gen = 0;
        for (int c = 0; c < 600; c++) begin
            rnd_e = ($urandom % 16) != 0;
            rnd_v = ($urandom % 4) != 0;
            rnd_l = ((gen % N) == N - 1) ^ (($urandom % 12) == 0);
            applyStimulus(rnd_e, rnd_v, rnd_l, ($urandom % 4) != 0, ($urandom % 32) == 0);
            checkOutput();
            if (last_accept) gen = rnd_l ? 0 : gen + 1;
        end
        for (int t = 0; t < 3; t++) begin
            applyStimulus(1, 0, 0, 1, 0);
            checkOutput();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
